// File: rtl/sobel_window_gen.sv
// sobel_window_gen: builds 3x3 neighbourhoods from a raster pixel stream using two line buffers
// and presents one window per interior pixel to the downstream Sobel kernel.
module sobel_window_gen #(
    parameter int P_DATA_BITS = 8,
    parameter int P_WIDTH     = 64,
    parameter int P_HEIGHT    = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [P_DATA_BITS-1:0]   i_data,
    input  logic                     i_sof,
    output logic                     o_valid,
    input  logic                     i_busy,
    output logic [9*P_DATA_BITS-1:0] o_data,
    output logic                     o_last
);
    localparam int B  = P_DATA_BITS;
    localparam int CW = $clog2(P_WIDTH);
    localparam int RW = $clog2(P_HEIGHT);

    logic [CW-1:0]  col, col_e;
    logic [RW-1:0]  row, row_e;
    logic [B-1:0]   lb1 [P_WIDTH];
    logic [B-1:0]   lb2 [P_WIDTH];
    logic [3*B-1:0] wc0, wc1, wc2, nc;
    logic [9*B-1:0] win_n;
    logic           acc, emit, last_col, last_row;

    assign o_ready  = !o_valid || !i_busy;
    assign acc      = i_valid && o_ready;
    // a start-of-frame pixel is treated as (0,0) for this very accept
    assign col_e    = i_sof ? '0 : col;
    assign row_e    = i_sof ? '0 : row;
    assign last_col = col_e == CW'(P_WIDTH - 1);
    assign last_row = row_e == RW'(P_HEIGHT - 1);
    assign emit     = acc && row_e >= RW'(2) && col_e >= CW'(2);
    // column word is {oldest line, middle line, newest pixel}
    assign nc       = {lb2[col_e], lb1[col_e], i_data};
    assign win_n    = {wc1[3*B-1 -: B], wc2[3*B-1 -: B], nc[3*B-1 -: B],
                       wc1[2*B-1 -: B], wc2[2*B-1 -: B], nc[2*B-1 -: B],
                       wc1[B-1:0],      wc2[B-1:0],      nc[B-1:0]};

    always_ff @(posedge i_clk) begin
        if (acc) begin
            lb2[col_e] <= lb1[col_e];
            lb1[col_e] <= i_data;
            wc0        <= wc1;
            wc1        <= wc2;
            wc2        <= nc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col     <= '0;
            row     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else begin
            if (acc) begin
                col <= last_col ? '0 : col_e + CW'(1);
                row <= !last_col ? row_e : (last_row ? '0 : row_e + RW'(1));
            end
            if (emit) begin
                o_valid <= 1'b1;
                o_data  <= win_n;
                o_last  <= last_row && last_col;
            end else if (o_valid && !i_busy) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end
endmodule
